spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one quad-SPI flash pad set between the CPU flash
// controller and the JTAG-side flash programmer. Ownership is granted in whole
// transactions, separated by a deselected guard gap, and a priority debugger
// may reclaim the pads from a CPU owner that has stayed idle long enough.
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES    = 2,
    parameter int PREEMPT_TIMEOUT = 4096
) (
    input  logic       ext_clk,
    input  logic       ext_rst,
    input  logic       cpu_req,
    output logic       cpu_gnt,
    input  logic       cpu_cs_n,
    input  logic       cpu_sck,
    input  logic [3:0] cpu_sdat_o,
    input  logic [3:0] cpu_sdat_oe,
    output logic [3:0] cpu_sdat_i,
    input  logic       dbg_req,
    output logic       dbg_gnt,
    input  logic       dbg_cs_n,
    input  logic       dbg_sck,
    input  logic [3:0] dbg_sdat_o,
    input  logic [3:0] dbg_sdat_oe,
    output logic [3:0] dbg_sdat_i,
    input  logic       dbg_prio,
    output logic       pad_cs_n,
    output logic       pad_sck,
    output logic [3:0] pad_sdat_o,
    output logic [3:0] pad_sdat_oe,
    input  logic [3:0] pad_sdat_i,
    output logic [1:0] owner,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_CPU = 2'b01,
        OWN_DBG = 2'b10,
        GUARD   = 2'b11
    } state_t;

    // GUARD_CYCLES is at most 15, so the guard count (0..14 while waiting,
    // 15 at most on the exit edge) always fits in four bits.
    localparam logic [3:0]  GUARD_LAST   = 4'(GUARD_CYCLES - 1);
    localparam logic [15:0] PREEMPT_LAST = 16'(PREEMPT_TIMEOUT - 1);
    localparam logic [15:0] IDLE_MAX     = 16'hFFFF;

    // last_owner encoding: 1 = debugger owned last, 0 = CPU owned last.
    state_t      state_r, next_state_s;
    logic        last_owner_r, next_last_owner_s;
    logic [3:0]  guard_cnt_r, next_guard_cnt_s;
    logic [15:0] idle_cnt_r, next_idle_cnt_s;
    logic        preempt_r, next_preempt_s;
    logic        preempt_cond_s;

    // Register state, history and counters; reset parks everything deselected.
    always_ff @(posedge ext_clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            guard_cnt_r  <= 4'd0;
            idle_cnt_r   <= 16'd0;
            preempt_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_last_owner_s;
            guard_cnt_r  <= next_guard_cnt_s;
            idle_cnt_r   <= next_idle_cnt_s;
            preempt_r    <= next_preempt_s;
        end
    end

    // Next-state, ownership history, guard/idle counters and preempt request.
    always_comb begin
        next_state_s      = state_r;
        next_last_owner_s = last_owner_r;
        next_guard_cnt_s  = 4'd0;
        next_preempt_s    = 1'b0;

        // The idle count only runs while a waiting priority debugger faces a
        // CPU owner with chip-select released; anything else restarts it.
        preempt_cond_s = (state_r == OWN_CPU) && cpu_cs_n && dbg_prio && dbg_req;
        if (!preempt_cond_s) begin
            next_idle_cnt_s = 16'd0;
        end else if (idle_cnt_r == IDLE_MAX) begin
            next_idle_cnt_s = idle_cnt_r;
        end else begin
            next_idle_cnt_s = idle_cnt_r + 16'd1;
        end

        case (state_r)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    if (dbg_prio) begin
                        next_state_s = OWN_DBG;
                    end else if (last_owner_r) begin
                        next_state_s = OWN_CPU;
                    end else begin
                        next_state_s = OWN_DBG;
                    end
                end else if (cpu_req) begin
                    next_state_s = OWN_CPU;
                end else if (dbg_req) begin
                    next_state_s = OWN_DBG;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN_CPU: begin
                // A voluntary release wins over a preemption in the same cycle.
                if (!cpu_req && cpu_cs_n) begin
                    next_state_s      = GUARD;
                    next_last_owner_s = 1'b0;
                end else if (preempt_cond_s && (idle_cnt_r == PREEMPT_LAST)) begin
                    next_state_s      = GUARD;
                    next_last_owner_s = 1'b0;
                    next_preempt_s    = 1'b1;
                end else begin
                    next_state_s = OWN_CPU;
                end
            end
            OWN_DBG: begin
                if (!dbg_req && dbg_cs_n) begin
                    next_state_s      = GUARD;
                    next_last_owner_s = 1'b1;
                end else begin
                    next_state_s = OWN_DBG;
                end
            end
            GUARD: begin
                if (guard_cnt_r >= GUARD_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s     = GUARD;
                    next_guard_cnt_s = guard_cnt_r + 4'd1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Decode grants and steer the pads from the registered owner, zero latency.
    always_comb begin
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        owner       = 2'b00;
        pad_cs_n    = 1'b1;
        pad_sck     = 1'b0;
        pad_sdat_o  = 4'b0000;
        pad_sdat_oe = 4'b0000;
        cpu_sdat_i  = 4'b0000;
        dbg_sdat_i  = 4'b0000;
        case (state_r)
            OWN_CPU: begin
                cpu_gnt     = 1'b1;
                owner       = 2'b01;
                pad_cs_n    = cpu_cs_n;
                pad_sck     = cpu_sck;
                pad_sdat_o  = cpu_sdat_o;
                pad_sdat_oe = cpu_sdat_oe;
                cpu_sdat_i  = pad_sdat_i;
            end
            OWN_DBG: begin
                dbg_gnt     = 1'b1;
                owner       = 2'b10;
                pad_cs_n    = dbg_cs_n;
                pad_sck     = dbg_sck;
                pad_sdat_o  = dbg_sdat_o;
                pad_sdat_oe = dbg_sdat_oe;
                dbg_sdat_i  = pad_sdat_i;
            end
            default: begin
                owner = 2'b00;
            end
        endcase
    end

    assign preempt = preempt_r;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: per-cycle vector table for spi_flash_arbiter with
// GUARD_CYCLES=2 and PREEMPT_TIMEOUT=8, plus a hand-written asynchronous
// reset sequence. Inputs change on the falling edge and outputs are
// compared 1 ns later, so each row describes one full clock cycle.
module tb_spi_flash_arbiter;

    logic       ext_clk = 1'b0;
    logic       ext_rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_cs_n = 1'b1, cpu_sck = 1'b0;
    logic [3:0] cpu_sdat_o = 4'h0, cpu_sdat_oe = 4'h0;
    logic       dbg_req = 1'b0, dbg_cs_n = 1'b1, dbg_sck = 1'b0, dbg_prio = 1'b0;
    logic [3:0] dbg_sdat_o = 4'h0, dbg_sdat_oe = 4'h0;
    logic [3:0] pad_sdat_i = 4'h0;
    logic       cpu_gnt, dbg_gnt, pad_cs_n, pad_sck, preempt;
    logic [3:0] cpu_sdat_i, dbg_sdat_i, pad_sdat_o, pad_sdat_oe;
    logic [1:0] owner;

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_arbiter #(.GUARD_CYCLES(2), .PREEMPT_TIMEOUT(8)) dut (
        .ext_clk(ext_clk), .ext_rst(ext_rst),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_cs_n(cpu_cs_n), .cpu_sck(cpu_sck),
        .cpu_sdat_o(cpu_sdat_o), .cpu_sdat_oe(cpu_sdat_oe), .cpu_sdat_i(cpu_sdat_i),
        .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_cs_n(dbg_cs_n), .dbg_sck(dbg_sck),
        .dbg_sdat_o(dbg_sdat_o), .dbg_sdat_oe(dbg_sdat_oe), .dbg_sdat_i(dbg_sdat_i),
        .dbg_prio(dbg_prio),
        .pad_cs_n(pad_cs_n), .pad_sck(pad_sck), .pad_sdat_o(pad_sdat_o),
        .pad_sdat_oe(pad_sdat_oe), .pad_sdat_i(pad_sdat_i),
        .owner(owner), .preempt(preempt)
    );

    // Free-running 10 ns clock.
    always #5 ext_clk = ~ext_clk;

    // One row = one cycle. ins = {rst, cpu_req, cpu_cs_n, dbg_req, dbg_cs_n, dbg_prio}
    typedef struct packed {
        logic [3:0] scen;
        logic [5:0] ins;
        logic [1:0] exp_owner;
        logic       exp_pre;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] sc, input logic [5:0] ins,
                       input logic [1:0] ow, input logic pe);
        vec_t v;
        v.scen = sc; v.ins = ins; v.exp_owner = ow; v.exp_pre = pe;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive the data lanes with an index-dependent pattern so CPU and debugger
    // values always differ and pad steering is observable.
    task automatic drive_data(input int idx);
        logic [3:0] k;
        k = idx[3:0];
        cpu_sck     = k[0];
        dbg_sck     = ~k[0];
        cpu_sdat_o  = k;
        cpu_sdat_oe = ~k;
        dbg_sdat_o  = k + 4'd3;
        dbg_sdat_oe = k ^ 4'h5;
        pad_sdat_i  = k ^ 4'h9;
    endtask

    // Expected full output word for a given expected owner and current inputs.
    function automatic logic [23:0] expect_word(input logic [1:0] ow, input logic pe);
        logic       cg, dg, pcs, psck;
        logic [3:0] pdo, poe, csi, dsi;
        cg = (ow == 2'b01);
        dg = (ow == 2'b10);
        pcs = 1'b1; psck = 1'b0; pdo = 4'h0; poe = 4'h0; csi = 4'h0; dsi = 4'h0;
        if (cg) begin
            pcs = cpu_cs_n; psck = cpu_sck; pdo = cpu_sdat_o; poe = cpu_sdat_oe; csi = pad_sdat_i;
        end else if (dg) begin
            pcs = dbg_cs_n; psck = dbg_sck; pdo = dbg_sdat_o; poe = dbg_sdat_oe; dsi = pad_sdat_i;
        end
        return {cg, dg, ow, pe, pcs, psck, pdo, poe, csi, dsi};
    endfunction

    function automatic logic [23:0] actual_word();
        return {cpu_gnt, dbg_gnt, owner, preempt, pad_cs_n, pad_sck,
                pad_sdat_o, pad_sdat_oe, cpu_sdat_i, dbg_sdat_i};
    endfunction

    initial begin
        // scen 1: reset holds everything idle even with requests present
        add(4'd1, 6'b1_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd1, 6'b1_1_1_1_1_0, 2'b00, 1'b0);
        // scen 2: tie at reset exit, dbg_prio=0 -> CPU; release; 2 guard cycles; idle; dbg
        add(4'd2, 6'b0_1_1_1_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_1_0_1_1_0, 2'b01, 1'b0);
        add(4'd2, 6'b0_0_0_1_1_0, 2'b01, 1'b0);
        add(4'd2, 6'b0_0_1_1_1_0, 2'b01, 1'b0);
        add(4'd2, 6'b0_0_1_1_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_0_1_1_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_0_1_1_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_0_1_1_0_0, 2'b10, 1'b0);
        add(4'd2, 6'b0_0_1_0_1_0, 2'b10, 1'b0);
        add(4'd2, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd2, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        // scen 3: single requester, req drops at cycle 5 with cs_n low, cs_n rises at 9
        add(4'd3, 6'b0_1_1_0_1_0, 2'b00, 1'b0);
        for (int c = 1; c <= 4; c++) add(4'd3, 6'b0_1_0_0_1_0, 2'b01, 1'b0);
        for (int c = 5; c <= 8; c++) add(4'd3, 6'b0_0_0_0_1_0, 2'b01, 1'b0);
        add(4'd3, 6'b0_0_1_0_1_0, 2'b01, 1'b0);
        add(4'd3, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd3, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd3, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        // scen 4: priority tie -> debugger, which is never preempted
        add(4'd4, 6'b0_1_1_1_1_1, 2'b00, 1'b0);
        add(4'd4, 6'b0_1_1_1_0_1, 2'b10, 1'b0);
        add(4'd4, 6'b0_1_1_0_1_1, 2'b10, 1'b0);
        add(4'd4, 6'b0_1_1_0_1_1, 2'b00, 1'b0);
        add(4'd4, 6'b0_1_1_0_1_1, 2'b00, 1'b0);
        // scen 5: tie with dbg_prio=0 after debugger owned last -> CPU
        add(4'd5, 6'b0_1_1_1_1_0, 2'b00, 1'b0);
        add(4'd5, 6'b0_1_1_1_1_0, 2'b01, 1'b0);
        // scen 6: preempt; 3 idle cycles, cs_n blip clears count, then 8 idle cycles
        for (int c = 0; c < 3; c++) add(4'd6, 6'b0_1_1_1_1_1, 2'b01, 1'b0);
        add(4'd6, 6'b0_1_0_1_1_1, 2'b01, 1'b0);
        for (int c = 0; c < 8; c++) add(4'd6, 6'b0_1_1_1_1_1, 2'b01, 1'b0);
        add(4'd6, 6'b0_1_1_1_1_1, 2'b00, 1'b1);
        add(4'd6, 6'b0_1_1_1_1_1, 2'b00, 1'b0);
        add(4'd6, 6'b0_1_1_1_1_1, 2'b00, 1'b0);
        add(4'd6, 6'b0_1_1_1_0_1, 2'b10, 1'b0);
        add(4'd6, 6'b0_0_1_0_1_1, 2'b10, 1'b0);
        add(4'd6, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd6, 6'b0_0_1_0_1_0, 2'b00, 1'b0);
        add(4'd6, 6'b0_0_1_0_1_0, 2'b00, 1'b0);

        foreach (vecs[i]) begin
            @(negedge ext_clk);
            {ext_rst, cpu_req, cpu_cs_n, dbg_req, dbg_cs_n, dbg_prio} = vecs[i].ins;
            drive_data(i);
            #1;
            check($sformatf("vec%0d_scen%0d", i, vecs[i].scen), 32'(actual_word()),
                  32'(expect_word(vecs[i].exp_owner, vecs[i].exp_pre)));
        end

        // Asynchronous reset while the debugger owns with cs_n low.
        @(negedge ext_clk);
        {ext_rst, cpu_req, cpu_cs_n, dbg_req, dbg_cs_n, dbg_prio} = 6'b0_0_1_1_0_0;
        drive_data(3);
        #1 check("arst_pre_idle", 32'(owner), 32'(2'b00));
        @(negedge ext_clk);
        #1 check("arst_own_dbg", 32'({dbg_gnt, owner, pad_cs_n}), 32'({1'b1, 2'b10, 1'b0}));
        @(posedge ext_clk);
        #2 ext_rst = 1'b1;
        #1 check("arst_deselect", 32'({pad_cs_n, dbg_gnt, owner, preempt, pad_sdat_oe}),
                 32'({1'b1, 1'b0, 2'b00, 1'b0, 4'h0}));
        @(negedge ext_clk);
        ext_rst = 1'b0;
        #1 check("arst_release_idle", 32'(owner), 32'(2'b00));
        @(negedge ext_clk);
        #1 check("arst_resume_dbg", 32'({dbg_gnt, owner}), 32'({1'b1, 2'b10}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
